imem_uart_loader: RTL

//  Serial instruction-memory loader: the in-system counterpart of the bench's backdoor imem preload.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_uart_loader_uart_rx_byte.sv | 118 +++++++++++
 rtl/imem_uart_loader.sv | 114 +++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the serial imem loader.
//   rx_state_t        receiver FSM states
//   DEFAULT_BAUD_DIV  clocks per UART bit at 50 MHz / 115200 baud
//   FRAME_BITS        8N1 frame length (start + 8 data + stop)
//   DATA_BITS         payload bits per frame
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned DEFAULT_BAUD_DIV = 434;
  localparam int unsigned FRAME_BITS       = 10;
  localparam int unsigned DATA_BITS        = FRAME_BITS - 2;

endpackage

// File: rtl/imem_uart_loader_uart_rx_byte.sv
// 8N1 UART byte receiver.
//   clk, rst     clock, asynchronous active-high reset
//   enable       receiver runs only while high; low forces IDLE
//   rxd          raw asynchronous serial input, idle high
//   byte_valid   one-cycle pulse in the stop-bit sample cycle, stop bit = 1
//   byte_data    received byte, valid with byte_valid
//   frame_err    one-cycle pulse in the stop-bit sample cycle, stop bit = 0
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);

  rx_state_t     state, state_next;
  logic          sync1, sync2, rxd_prev;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shreg, shreg_next;
  logic          start_pend, start_pend_next;
  logic          fall, tick;

  assign fall      = rxd_prev & ~sync2;
  // The counter expires as it reaches 1, so a load of N gives N clocks.
  assign tick      = (cnt == CW'(1));
  assign byte_data = shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      rxd_prev   <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      start_pend <= 1'b0;
    end else begin
      sync1      <= rxd;
      sync2      <= sync1;
      rxd_prev   <= sync2;
      state      <= state_next;
      cnt        <= cnt_next;
      bit_idx    <= bit_idx_next;
      shreg      <= shreg_next;
      start_pend <= start_pend_next;
    end
  end

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    bit_idx_next    = bit_idx;
    shreg_next      = shreg;
    start_pend_next = 1'b0;
    byte_valid      = 1'b0;
    frame_err       = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (fall || start_pend) begin
            state_next = START;
            cnt_next   = HALF;
          end
        end
        START: begin
          if (tick) begin
            cnt_next = FULL;
            if (sync2) begin
              state_next = IDLE;
            end else begin
              state_next   = DATA;
              bit_idx_next = '0;
            end
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            cnt_next     = FULL;
            shreg_next   = {sync2, shreg[7:1]};
            bit_idx_next = bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_BITS - 1)) state_next = STOP;
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            state_next      = IDLE;
            byte_valid      = sync2;
            frame_err       = ~sync2;
            // A start edge seen while still in STOP is replayed from IDLE.
            start_pend_next = fall;
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Serial instruction-memory loader: receives 8N1 bytes while io_load_imem
// is high, packs them little-endian into 32-bit words and writes them to
// consecutive imem word addresses starting at 0.
//   io_clk, io_reset  clock, asynchronous active-high reset
//   io_load_imem      load-mode enable (level); rising edge restarts a load
//   io_uart0_rxd      async serial input, idle high
//   imem_wr           one-cycle write strobe
//   imem_addr         word address, valid with imem_wr
//   imem_wdata        {byte3,byte2,byte1,byte0}, valid with imem_wr
//   busy              registered io_load_imem
//   word_count        words written since load start, saturating at 2^ADDR_WIDTH
//   frame_err         sticky: a stop bit was sampled 0
//   overflow          sticky: address wrapped past 2^ADDR_WIDTH-1
//   checksum          wrapping sum of written words (LOADER_CHECKSUM_EN only)
// Optional feature macro: LOADER_CHECKSUM_EN
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  io_clk,
  input  logic                  io_reset,
  input  logic                  io_load_imem,
  input  logic                  io_uart0_rxd,
  output logic                  imem_wr,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  frame_err,
  output logic                  overflow
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]           checksum
`endif
);

  localparam logic [ADDR_WIDTH:0] WC_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic                  load_q, load_rise;
  logic                  rx_valid, rx_ferr;
  logic [7:0]            rx_byte;
  logic [1:0]            lane;
  logic [23:0]           lanes;
  logic [ADDR_WIDTH-1:0] addr;

  assign load_rise = io_load_imem & ~load_q;
  assign busy      = load_q;

  uart_rx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .clk       (io_clk),
    .rst       (io_reset),
    .enable    (io_load_imem),
    .rxd       (io_uart0_rxd),
    .byte_valid(rx_valid),
    .byte_data (rx_byte),
    .frame_err (rx_ferr)
  );

  // Bytes 0..2 shift in from the top so that after three of them
  // lanes = {byte2,byte1,byte0}; byte3 completes the word directly.
  always_ff @(posedge io_clk or posedge io_reset) begin
    if (io_reset) begin
      load_q     <= 1'b0;
      imem_wr    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      lane       <= '0;
      lanes      <= '0;
      addr       <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      load_q  <= io_load_imem;
      imem_wr <= 1'b0;
      if (load_rise) begin
        addr       <= '0;
        lane       <= '0;
        word_count <= '0;
        frame_err  <= 1'b0;
        overflow   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        checksum   <= '0;
`endif
      end else begin
        if (rx_ferr) frame_err <= 1'b1;
        if (rx_valid) begin
          lane <= lane + 2'd1;
          if (lane == 2'd3) begin
            imem_wr    <= 1'b1;
            imem_addr  <= addr;
            imem_wdata <= {rx_byte, lanes};
            addr       <= addr + 1'b1;
            if (&addr) overflow <= 1'b1;
            if (word_count != WC_MAX) word_count <= word_count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            checksum   <= checksum + {rx_byte, lanes};
`endif
          end else begin
            lanes <= {rx_byte, lanes[23:8]};
          end
        end
      end
    end
  end

endmodule
